pattern_apb_ctrl: RTL

// - APB-programmable controller for the serial pattern detector: holds the target

---
 rtl/pattern_apb_ctrl.sv | 175 +++++++++++++++++
 1 files changed

// File: rtl/pattern_apb_ctrl.sv
// APB-programmed serial pattern detector: PAT/MASK/CTRL registers, shift/compare FSM,
// saturating match counter and sticky HIT. Define PAT_IRQ_EN to add CTRL.IE and the irq output.
module pattern_apb_ctrl #(
  parameter int PW    = 5,
  parameter int CNT_W = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [3:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  input  logic        data_in,
  input  logic        data_valid,
`ifdef PAT_IRQ_EN
  output logic        pattern_det,
  output logic        irq
`else
  output logic        pattern_det
`endif
);

  localparam int FW = $clog2(PW + 1);
  localparam logic [FW-1:0]    FILL_FULL = FW'(PW);
  localparam logic [CNT_W-1:0] CNT_MAX   = '1;

  typedef enum logic [1:0] {IDLE, FILL, ARMED} state_t;

  state_t           state, state_nx;
  logic             en, overlap, ie_rd;
  logic [PW-1:0]    pat, mask, sr, sr_nx, sr_shift;
  logic [FW-1:0]    fill, fill_nx, fill_inc;
  logic [CNT_W-1:0] count;
  logic             hit_sticky, hit;
  logic             access, addr_ok, wr;
  logic             ctrl_wr, pat_wr, mask_wr, stat_wr;
  logic             clr, disable_wr, flush_wr;
  logic             pwdata_unused;

  assign access     = psel & penable;
  assign addr_ok    = (paddr[1:0] == 2'b00);
  assign wr         = access & pwrite & addr_ok;
  assign ctrl_wr    = wr & (paddr[3:2] == 2'd0);
  assign pat_wr     = wr & (paddr[3:2] == 2'd1);
  assign mask_wr    = wr & (paddr[3:2] == 2'd2);
  assign stat_wr    = wr & (paddr[3:2] == 2'd3);
  assign clr        = ctrl_wr & pwdata[2];
  assign disable_wr = ctrl_wr & ~pwdata[0];
  // Reprogramming the pattern while running invalidates the bits already collected
  assign flush_wr   = disable_wr | ((pat_wr | mask_wr) & en);
  assign sr_shift   = {sr[PW-2:0], data_in};
  assign fill_inc   = fill + FW'(1);
  assign pwdata_unused = ^pwdata;

  assign pready  = access;
  assign pslverr = access & ~addr_ok;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      sr    <= '0;
      fill  <= '0;
    end else begin
      state <= state_nx;
      sr    <= sr_nx;
      fill  <= fill_nx;
    end
  end

  always_comb begin
    state_nx = state;
    sr_nx    = sr;
    fill_nx  = fill;
    hit      = 1'b0;
    if (disable_wr) begin
      state_nx = IDLE;
      sr_nx    = '0;
      fill_nx  = '0;
    end else if (state == IDLE) begin
      sr_nx   = '0;
      fill_nx = '0;
      if (ctrl_wr) state_nx = FILL;
    end else if (flush_wr) begin
      state_nx = FILL;
      sr_nx    = '0;
      fill_nx  = '0;
    end else if (data_valid) begin
      sr_nx = sr_shift;
      if (state == FILL) begin
        fill_nx = fill_inc;
        if (fill_inc == FILL_FULL) state_nx = ARMED;
      end
      // The bit that completes the fill is compared in the same cycle
      if (state == ARMED || (state == FILL && fill_inc == FILL_FULL))
        hit = (((sr_shift ^ pat) & mask) == '0);
      if (hit) begin
        if (overlap) begin
          state_nx = ARMED;
          fill_nx  = FILL_FULL;
        end else begin
          state_nx = FILL;
          sr_nx    = '0;
          fill_nx  = '0;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      en          <= 1'b0;
      overlap     <= 1'b0;
      pat         <= '0;
      mask        <= '0;
      count       <= '0;
      hit_sticky  <= 1'b0;
      pattern_det <= 1'b0;
    end else begin
      pattern_det <= hit;
      if (ctrl_wr) begin
        en      <= pwdata[0];
        overlap <= pwdata[1];
      end
      if (pat_wr)  pat  <= pwdata[PW-1:0];
      if (mask_wr) mask <= pwdata[PW-1:0];
      // CLR beats a simultaneous increment; a new hit beats a simultaneous W1C
      if (clr)
        count <= '0;
      else if (hit && count != CNT_MAX)
        count <= count + CNT_W'(1);
      if (hit)
        hit_sticky <= 1'b1;
      else if (stat_wr && pwdata[16])
        hit_sticky <= 1'b0;
    end
  end

`ifdef PAT_IRQ_EN
  logic ie;

  always_ff @(posedge clk) begin
    if (rst) begin
      ie  <= 1'b0;
      irq <= 1'b0;
    end else begin
      if (ctrl_wr) ie <= pwdata[3];
      irq <= hit_sticky & ie;
    end
  end

  assign ie_rd = ie;
`else
  assign ie_rd = 1'b0;
`endif

  always_comb begin
    prdata = '0;
    if (access && !pwrite && addr_ok) begin
      case (paddr[3:2])
        2'd0: prdata = {28'd0, ie_rd, 1'b0, overlap, en};
        2'd1: prdata[PW-1:0] = pat;
        2'd2: prdata[PW-1:0] = mask;
        default: begin
          prdata[CNT_W-1:0] = count;
          prdata[16]        = hit_sticky;
        end
      endcase
    end
  end

endmodule
